axis_word_unpacker: RTL and testbench
=====================================

Name: axis_word_unpacker

Overview:
- Receive-side width converter for the team's AXI-Stream bus. It accepts BUS_W-wide beats with per-word keep and last, and emits one WORD_W word per cycle on a narrow AXI-Stream output.
- It sits behind any wide AXIS producer, such as the AXIS source VIP or DMA, and feeds word-serial consumers.
- Null (keep=0) word slots are removed; packet boundaries are preserved on m_last.

Parameters:
- WORD_W, 8, bits per word.
- BUS_W, 32, input bus width in bits; must be an integer multiple of WORD_W.
- WORDS_PER_BEAT, BUS_W/WORD_W (derived, localparam), word lanes per input beat.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accept.
- s_data  in  WORDS_PER_BEAT*WORD_W  packed words; lane 0 is at the LSBs.
- s_keep  in  WORDS_PER_BEAT  per-lane keep.
- s_last  in  1  final beat of packet.
- m_valid  out  1  output word valid.
- m_ready  in  1  output word accept.
- m_data  out  WORD_W  output word.
- m_last  out  1  final word of packet.
- err_null_last  out  1  one-cycle pulse: a beat arrived with s_last=1 and s_keep=0.

Behaviour:
- Reset: all state clears on the rst clock edge. Outputs after reset: s_ready=1, m_valid=0, m_data=0, m_last=0, err_null_last=0. Reset mid-packet discards the held beat with no partial flush.
- State: hold register (data, remaining-keep mask rem, last flag) plus busy bit. busy=0 is IDLE; busy=1 is DRAIN.
- Outputs in DRAIN:
  - m_valid=busy.
  - m_data = lane at the lowest set bit of rem.
  - m_last = held_last AND rem has exactly one bit set.
- Word handshake: on m_valid&&m_ready, clear the lowest set bit of rem. When rem would become zero, busy clears unless a new beat is accepted in the same cycle.
- s_ready = !busy OR (m_ready AND rem has exactly one bit set). This gives back-to-back beats with no bubble.
- Latency: a beat accepted at edge N presents its first word at cycle N+1. A beat with K kept lanes occupies K output cycles. Sustained throughput is 1 word/cycle when m_ready=1.
- Lane order: ascending lane index. Non-contiguous keep patterns are legal; holes are skipped.
- keep=0, last=0 beat: accepted and dropped; busy stays 0; consumes one cycle.
- keep=0, last=1 beat: loaded as a single word of data 0 with m_last=1. err_null_last pulses in the cycle after acceptance.
- m_data/m_last hold stable while m_valid=1 and m_ready=0 (AXIS rule).
- s_data, s_keep and s_last are ignored when s_valid=0.

Optional Feature:
- Macro AXIS_WORD_UNPACKER_STATS_EN.
- When defined, adds output ports stat_words[31:0] and stat_pkts[31:0]:
  - stat_words counts accepted output words; stat_pkts counts accepted m_last words.
  - Both saturate at 32'hFFFF_FFFF and clear on rst.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package axis_unpack_pkg holds:
  - function onehot_lsb(mask) returning the lowest set bit;
  - function is_single(mask);
  - localparam STAT_W=32.
- One natural sub-module: lsb_lane_select. It takes rem and s_data-width data and returns the selected word, the lane one-hot and the single flag. It is combinational and reused for m_data muxing.

Test Plan:
- Single beat s_data=32'h44332211, keep=4'b1111, last=1, m_ready=1 -> words 11,22,33,44 on consecutive cycles starting the cycle after accept; m_last only on 44.
- Sparse keep 4'b1010 with data 32'hDDCCBBAA, last=1 -> words BB then DD (m_last=1). Next beat is accepted in the same cycle DD is taken.
- Back-to-back beats, all keep=4'hF, 3-beat packet, m_ready=1 -> 12 words in 12 consecutive cycles, no bubble; m_last on word 12.
- Backpressure: m_ready toggles 1,0,0,1 during a beat -> m_data/m_last stable while stalled; s_ready=0 until the final kept lane is taken.
- Null beats: keep=0/last=0 -> dropped with no m_valid. Then keep=0/last=1 -> one word 00 with m_last=1 and a single err_null_last pulse.
- Reset mid-DRAIN with 2 lanes remaining -> next cycle m_valid=0, s_ready=1; the following packet unpacks correctly. With AXIS_WORD_UNPACKER_STATS_EN defined, counters read 0 after reset.

Source files
------------

// File: rtl/axis_unpack_pkg.sv
// axis_unpack_pkg: shared helpers for the AXI-Stream word unpacker.
package axis_unpack_pkg;
    localparam int STAT_W    = 32;
    localparam int MAX_LANES = 64;

    function automatic logic [MAX_LANES-1:0] onehot_lsb(input logic [MAX_LANES-1:0] m);
        return m & (~m + MAX_LANES'(1));
    endfunction

    function automatic logic is_single(input logic [MAX_LANES-1:0] m);
        return (m != '0) && ((m & (m - MAX_LANES'(1))) == '0);
    endfunction
endpackage

// File: rtl/lsb_lane_select.sv
// lsb_lane_select: picks the word at the lowest set bit of a lane mask.
module lsb_lane_select
    import axis_unpack_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int LANES  = 4
) (
    input  logic [LANES-1:0]        rem_i,
    input  logic [LANES*WORD_W-1:0] data_i,
    output logic [WORD_W-1:0]       word_o,
    output logic [LANES-1:0]        onehot_o,
    output logic                    single_o
);
    logic [MAX_LANES-1:0] rem_x;

    assign rem_x    = MAX_LANES'(rem_i);
    assign onehot_o = LANES'(onehot_lsb(rem_x));
    assign single_o = is_single(rem_x);

    always_comb begin
        word_o = '0;
        for (int i = 0; i < LANES; i++)
            word_o = word_o | (onehot_o[i] ? data_i[i*WORD_W +: WORD_W] : '0);
    end
endmodule

// File: rtl/axis_word_unpacker.sv
// axis_word_unpacker: wide AXIS beats to one word per cycle, null lanes removed.
// Optional AXIS_WORD_UNPACKER_STATS_EN adds saturating word/packet counters.
module axis_word_unpacker
    import axis_unpack_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int BUS_W  = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [BUS_W-1:0]                 s_data,
    input  logic [BUS_W/WORD_W-1:0]          s_keep,
    input  logic                             s_last,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [WORD_W-1:0]                m_data,
    output logic                             m_last,
    output logic                             err_null_last
`ifdef AXIS_WORD_UNPACKER_STATS_EN
    ,
    output logic [STAT_W-1:0]                stat_words,
    output logic [STAT_W-1:0]                stat_pkts
`endif
);
    localparam int WORDS_PER_BEAT = BUS_W / WORD_W;

    logic [BUS_W-1:0]          data_q;
    logic [WORDS_PER_BEAT-1:0] rem_q;
    logic                      last_q;
    logic                      busy_q;
    logic                      err_q;
    logic [WORDS_PER_BEAT-1:0] onehot;
    logic [WORD_W-1:0]         word;
    logic                      single;
    logic                      accept;
    logic                      take;

    lsb_lane_select #(.WORD_W(WORD_W), .LANES(WORDS_PER_BEAT)) u_sel (
        .rem_i   (rem_q),
        .data_i  (data_q),
        .word_o  (word),
        .onehot_o(onehot),
        .single_o(single)
    );

    assign s_ready       = !busy_q || (m_ready && single);
    assign m_valid       = busy_q;
    assign m_data        = word;
    assign m_last        = busy_q && last_q && single;
    assign err_null_last = err_q;
    assign accept        = s_valid && s_ready;
    assign take          = busy_q && m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            rem_q  <= '0;
            last_q <= 1'b0;
            busy_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            err_q <= accept && (s_keep == '0) && s_last;
            if (accept && (s_keep != '0)) begin
                data_q <= s_data;
                rem_q  <= s_keep;
                last_q <= s_last;
                busy_q <= 1'b1;
            end else if (accept && s_last) begin
                // an empty closing beat still has to mark the packet end downstream
                data_q <= '0;
                rem_q  <= WORDS_PER_BEAT'(1);
                last_q <= 1'b1;
                busy_q <= 1'b1;
            end else if (accept) begin
                rem_q  <= '0;
                busy_q <= 1'b0;
            end else if (take) begin
                rem_q  <= rem_q & ~onehot;
                busy_q <= !single;
            end
        end
    end

`ifdef AXIS_WORD_UNPACKER_STATS_EN
    logic [STAT_W-1:0] words_q;
    logic [STAT_W-1:0] pkts_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            words_q <= '0;
            pkts_q  <= '0;
        end else begin
            if (take && !(&words_q))
                words_q <= words_q + STAT_W'(1);
            if (take && m_last && !(&pkts_q))
                pkts_q <= pkts_q + STAT_W'(1);
        end
    end

    assign stat_words = words_q;
    assign stat_pkts  = pkts_q;
`endif
endmodule

// File: tb/tb_axis_word_unpacker.sv
// tb_axis_word_unpacker: directed and random stimulus against a word-queue model.
module tb_axis_word_unpacker;
    localparam int W = 8;
    localparam int B = 32;
    localparam int N = B / W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [B-1:0] s_data = '0;
    logic [N-1:0] s_keep = '0;
    logic         s_last = 1'b0;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [W-1:0] m_data;
    logic         m_last;
    logic         err_null_last;
`ifdef AXIS_WORD_UNPACKER_STATS_EN
    logic [31:0]  stat_words;
    logic [31:0]  stat_pkts;
    logic [31:0]  words_exp = '0;
    logic [31:0]  pkts_exp = '0;
`endif

    axis_word_unpacker #(.WORD_W(W), .BUS_W(B)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_keep       (s_keep),
        .s_last       (s_last),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last),
        .err_null_last(err_null_last)
`ifdef AXIS_WORD_UNPACKER_STATS_EN
        ,
        .stat_words   (stat_words),
        .stat_pkts    (stat_pkts)
`endif
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [W:0] q[$];
    logic       err_exp = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // The model is simply the ordered list of words still owed downstream.
    task automatic tick(input logic sv, input logic [B-1:0] d, input logic [N-1:0] k,
                        input logic l, input logic mr, input logic r, output logic acc);
        logic       tk;
        logic       rdy;
        logic [W:0] hd;
        int         hi;
        @(negedge clk);
        s_valid = sv;
        s_data  = d;
        s_keep  = k;
        s_last  = l;
        m_ready = mr;
        rst     = r;
        #1;
        hd  = (q.size() != 0) ? q[0] : '0;
        rdy = (q.size() == 0) || (mr && q.size() == 1);
        chk("m_valid", m_valid, q.size() != 0);
        chk("m_data", m_data, hd[W-1:0]);
        chk("m_last", m_last, hd[W]);
        chk("s_ready", s_ready, rdy);
        chk("err_null_last", err_null_last, err_exp);
`ifdef AXIS_WORD_UNPACKER_STATS_EN
        chk("stat_words", stat_words, words_exp);
        chk("stat_pkts", stat_pkts, pkts_exp);
`endif
        acc = sv && rdy && !r;
        tk  = (q.size() != 0) && mr;
        @(posedge clk);
        if (r) begin
            q.delete();
            err_exp = 1'b0;
`ifdef AXIS_WORD_UNPACKER_STATS_EN
            words_exp = '0;
            pkts_exp  = '0;
`endif
        end else begin
            if (tk) begin
`ifdef AXIS_WORD_UNPACKER_STATS_EN
                words_exp++;
                if (hd[W]) pkts_exp++;
`endif
                void'(q.pop_front());
            end
            err_exp = acc && (k == '0) && l;
            if (acc) begin
                hi = -1;
                for (int i = 0; i < N; i++) if (k[i]) hi = i;
                if (k == '0 && l) q.push_back({1'b1, {W{1'b0}}});
                for (int i = 0; i < N; i++)
                    if (k[i]) q.push_back({l && (i == hi), d[i*W +: W]});
            end
        end
    endtask

    task automatic send(input logic [B-1:0] d, input logic [N-1:0] k, input logic l, input bit rnd);
        logic a;
        for (int t = 0; t < 40; t++) begin
            tick(1'b1, d, k, l, rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, a);
            if (a) return;
        end
        n_chk++;
        n_fail++;
        $display("FAIL send_timeout: beat %0h not accepted within 40 cycles", d);
    endtask

    task automatic idle(input int n, input logic mr);
        logic a;
        for (int t = 0; t < n; t++) tick(1'b0, '0, '0, 1'b0, mr, 1'b0, a);
    endtask

    initial begin
        logic a;
        repeat (2) @(posedge clk);
        send(32'h44332211, 4'b1111, 1'b1, 1'b0);
        idle(6, 1'b1);
        send(32'hDDCCBBAA, 4'b1010, 1'b1, 1'b0);
        send(32'h0F0E0D0C, 4'b1111, 1'b1, 1'b0);
        idle(6, 1'b1);
        send(32'h03020100, 4'hF, 1'b0, 1'b0);
        send(32'h07060504, 4'hF, 1'b0, 1'b0);
        send(32'h0B0A0908, 4'hF, 1'b1, 1'b0);
        idle(6, 1'b1);
        send(32'h88776655, 4'b1111, 1'b1, 1'b0);
        tick(1'b1, 32'h12345678, 4'hF, 1'b0, 1'b1, 1'b0, a);
        tick(1'b1, 32'h12345678, 4'hF, 1'b0, 1'b0, 1'b0, a);
        tick(1'b1, 32'h12345678, 4'hF, 1'b0, 1'b0, 1'b0, a);
        tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, a);
        idle(6, 1'b1);
        send(32'hA5A5A5A5, 4'b0000, 1'b0, 1'b0);
        idle(2, 1'b1);
        send(32'h5A5A5A5A, 4'b0000, 1'b1, 1'b0);
        idle(4, 1'b1);
        send(32'hCAFEBABE, 4'b1111, 1'b1, 1'b0);
        idle(2, 1'b1);
        tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, a);
        idle(1, 1'b1);
        send(32'h99887766, 4'b0110, 1'b1, 1'b0);
        idle(4, 1'b1);
        for (int t = 0; t < 1500; t++)
            tick(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'b0, a);
        for (int t = 0; t < 100; t++)
            send($urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);
        idle(10, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
